// File: rtl/velocity_estimator.sv
// Velocity estimator: samples a signed 32-bit encoder position once per sample
// period and forms the wrap-safe per-period delta, clamped to VEL_WIDTH. The
// clamped delta is then smoothed with a 2^AVG_LOG2-deep moving average.
module velocity_estimator #(
  parameter int SAMPLE_CYCLES = 150000,
  parameter int AVG_LOG2      = 3,
  parameter int VEL_WIDTH     = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [31:0]                 position_in,
  output logic signed [VEL_WIDTH-1:0] delta_out,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        velocity_valid,
  output logic                        sat_flag
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int ACC_W = VEL_WIDTH + AVG_LOG2;
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [31:0]                 prev_q;
  logic signed [VEL_WIDTH-1:0] buf_q [DEPTH];
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     acc_d;
  logic [PTR_W-1:0]            wp_q;
  logic [PTR_W-1:0]            wp_d;
  logic signed [VEL_WIDTH-1:0] delta_q, vel_q;
  logic                        valid_q, sat_q, pend_q;

  logic                        tick;
  logic                        sample;
  logic                        prev_ld;
  logic signed [31:0]          raw;
  logic signed [VEL_WIDTH-1:0] sat_val;
  logic                        clip;

  assign tick = enable && (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));

  // Modular 32-bit subtraction keeps deltas correct across counter wrap.
  assign raw = $signed(position_in - prev_q);

  // Clamp the raw delta to the velocity width; a full 32-bit width never clips.
  generate
    if (VEL_WIDTH == 32) begin : g_nosat
      assign sat_val = raw;
      assign clip    = 1'b0;
    end else begin : g_sat
      localparam logic signed [31:0] VMAX = (32'sd1 <<< (VEL_WIDTH - 1)) - 32'sd1;
      localparam logic signed [31:0] VMIN = -(32'sd1 <<< (VEL_WIDTH - 1));
      // Select the clipped or pass-through delta.
      always_comb begin
        sat_val = raw[VEL_WIDTH-1:0];
        clip    = 1'b0;
        if (raw > VMAX) begin
          sat_val = VMAX[VEL_WIDTH-1:0];
          clip    = 1'b1;
        end else if (raw < VMIN) begin
          sat_val = VMIN[VEL_WIDTH-1:0];
          clip    = 1'b1;
        end
      end
    end
  endgenerate

  // Next-state logic plus the per-tick strobes derived from the current state.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    prev_ld = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: begin
          prev_ld = tick;
          if (tick) state_d = RUN;
        end
        RUN: begin
          prev_ld = tick;
          sample  = tick;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Running sum: add the new delta, drop the one it overwrites in the ring.
  assign acc_d = acc_q + ACC_W'(sat_val) - ACC_W'(buf_q[wp_q]);
  assign wp_d  = (AVG_LOG2 == 0) ? '0 : wp_q + 1'b1;

  // State register and sample-period counter; counting halts at 0 when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!enable || tick) cnt_q <= '0;
      else                 cnt_q <= cnt_q + 1'b1;
    end
  end

  // Previous position is only meaningful after a PRIME, so disable leaves it alone.
  always_ff @(posedge clk) begin
    if (reset)        prev_q <= '0;
    else if (prev_ld) prev_q <= position_in;
  end

  // Moving-average ring entries, each cleared on reset or disable.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
      // Capture the clamped delta when the write pointer selects this entry.
      always_ff @(posedge clk) begin
        if (reset || !enable)                        buf_q[gi] <= '0;
        else if (sample && (wp_q == PTR_W'(gi)))     buf_q[gi] <= sat_val;
      end
    end
  endgenerate

  // Two-stage output pipeline: delta/accumulator at T+1, average and valid at T+2.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      acc_q   <= '0;
      wp_q    <= '0;
      delta_q <= '0;
      sat_q   <= 1'b0;
      vel_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      pend_q  <= sample;
      valid_q <= pend_q;
      if (sample) begin
        delta_q <= sat_val;
        sat_q   <= clip;
        acc_q   <= acc_d;
        wp_q    <= wp_d;
      end
      if (pend_q) vel_q <= VEL_WIDTH'(acc_q >>> AVG_LOG2);
    end
  end

  assign delta_out      = delta_q;
  assign velocity       = vel_q;
  assign velocity_valid = valid_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_velocity_estimator.sv
// Directed bench for velocity_estimator: a 24-bit/1000-cycle instance for ramp,
// wrap, disable and reset cases, and an 8-bit/20-cycle instance for clamping.
module tb_velocity_estimator;

  localparam int SCA = 1000;
  localparam int SCB = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, rst_b, en_b;
  logic [31:0] pos_a, pos_b;
  logic signed [23:0] dlt_a, vel_a;
  logic signed [7:0]  dlt_b, vel_b;
  logic        vld_a, sat_a, vld_b, sat_b;

  velocity_estimator #(.SAMPLE_CYCLES(SCA), .AVG_LOG2(2), .VEL_WIDTH(24)) u_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .position_in(pos_a),
    .delta_out(dlt_a), .velocity(vel_a), .velocity_valid(vld_a), .sat_flag(sat_a));

  velocity_estimator #(.SAMPLE_CYCLES(SCB), .AVG_LOG2(2), .VEL_WIDTH(8)) u_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .position_in(pos_b),
    .delta_out(dlt_b), .velocity(vel_b), .velocity_valid(vld_b), .sat_flag(sat_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit sel = 1'b0;  // 0 selects instance a, 1 selects instance b
  logic signed [31:0] dlt_s, vel_s;
  logic vld_s, sat_s;
  assign dlt_s = sel ? {{24{dlt_b[7]}}, dlt_b} : {{8{dlt_a[23]}}, dlt_a};
  assign vel_s = sel ? {{24{vel_b[7]}}, vel_b} : {{8{vel_a[23]}}, vel_a};
  assign vld_s = sel ? vld_b : vld_a;
  assign sat_s = sel ? sat_b : sat_a;

  int n_chk = 0;
  int n_pass = 0;
  int last_v = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sc();
    return sel ? SCB : SCA;
  endfunction

  task automatic set_pos(input logic [31:0] p);
    if (sel) pos_b = p; else pos_a = p;
  endtask

  task automatic set_en(input logic e);
    if (sel) en_b = e; else en_a = e;
  endtask

  task automatic set_rst(input logic r);
    if (sel) rst_b = r; else rst_a = r;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " delta"}, dlt_s, 0);
    check({tag, " vel"},   vel_s, 0);
    check({tag, " valid"}, vld_s, 0);
    check({tag, " sat"},   sat_s, 0);
  endtask

  // Enable from IDLE: p0 is latched at the prime tick, p1 is the next sample.
  task automatic start(input logic [31:0] p0, input logic [31:0] p1);
    set_pos(p0);
    set_en(1'b1);
    last_v = cyc;
    repeat (sc()) step();
    set_pos(p1);
  endtask

  task automatic expect_v(input string tag, input int gap, input int d, input int v, input int s);
    bit got = 1'b0;
    for (int i = 0; i < 2 * sc() + 10 && !got; i++) begin
      step();
      if (vld_s) got = 1'b1;
    end
    if (!got) begin
      check({tag, " timeout"}, 0, 1);
    end else begin
      $display("%s: valid at cycle %0d delta=%0d velocity=%0d sat=%0d",
               tag, cyc, dlt_s, vel_s, sat_s);
      check({tag, " gap"}, cyc - last_v, gap);
      last_v = cyc;
      check({tag, " delta"}, dlt_s, d);
      check({tag, " vel"},   vel_s, v);
      check({tag, " sat"},   sat_s, s);
      step();
      check({tag, " pulse"}, vld_s, 0);
    end
  endtask

  initial begin
    int p;
    int ramp1 [5] = '{1, 2, 3, 5, 5};
    int ramp2 [4] = '{-1, -2, -3, -3};
    bit seen;

    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0;  en_b = 1'b0;
    pos_a = '0;   pos_b = '0;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // ---------------- instance a ----------------
    sel = 1'b0;
    check_zero("reset");

    // +5 per period ramp
    p = 5;
    start(32'd0, 32'd5);
    for (int k = 0; k < 5; k++) begin
      expect_v($sformatf("up%0d", k), (k == 0) ? 2 * SCA + 1 : SCA, 5, ramp1[k], 0);
      p += 5;
      set_pos(p);
    end

    // drop enable in the cycle after a tick
    repeat (SCA - 2) step();
    check("drop delta T+1", dlt_s, 5);
    set_en(1'b0);
    step();
    check_zero("drop");
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= vld_s;
    end
    check("drop no valid", seen, 0);
    start(p, p + 5);
    p += 5;
    expect_v("reen0", 2 * SCA + 1, 5, 1, 0);
    p += 5;
    set_pos(p);
    expect_v("reen1", SCA, 5, 2, 0);

    // -3 per period ramp
    set_en(1'b0);
    repeat (2) step();
    p = 1000;
    start(p, p - 3);
    for (int k = 0; k < 4; k++) begin
      expect_v($sformatf("dn%0d", k), (k == 0) ? 2 * SCA + 1 : SCA, -3, ramp2[k], 0);
      p -= 3;
      set_pos(p - 3);
    end

    // signed wrap 0x7FFFFFFE -> 0x80000003
    set_en(1'b0);
    repeat (2) step();
    start(32'h7FFF_FFFE, 32'h8000_0003);
    expect_v("wrap", 2 * SCA + 1, 5, 1, 0);
    p = 32'h8000_0008;
    set_pos(p);
    expect_v("wrap2", SCA, 5, 2, 0);
    p += 5;
    set_pos(p);

    // one-cycle reset mid-RUN with enable held high
    repeat (100) step();
    set_rst(1'b1);
    step();
    set_rst(1'b0);
    check_zero("rst mid");
    last_v = cyc;
    repeat (SCA) step();
    set_pos(p + 5);
    expect_v("rst ramp", 2 * SCA + 1, 5, 1, 0);
    set_en(1'b0);

    // ---------------- instance b: 8-bit clamping ----------------
    sel = 1'b1;
    step();
    check_zero("b idle");
    start(32'd0, 32'd200);
    expect_v("clip+", 2 * SCB + 1, 127, 31, 1);
    set_pos(32'd210);
    expect_v("noclip", SCB, 10, 34, 0);
    set_pos(32'd10);
    expect_v("clip-", SCB, -128, 2, 1);

    // reset and enable both high: reset must win
    set_rst(1'b1);
    seen = 1'b0;
    repeat (3 * SCB) begin
      step();
      seen |= vld_s;
    end
    check("rst+en no valid", seen, 0);
    check_zero("rst+en");
    set_rst(1'b0);
    last_v = cyc;
    repeat (SCB) step();
    set_pos(32'd15);
    expect_v("rst+en ramp", 2 * SCB + 1, 5, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/velocity_estimator.md
Name: velocity_estimator

Overview:
Downstream consumer of the quadrature encoder's signed 32-bit position count. It samples position at a fixed period, forms the per-period delta with wrap-safe arithmetic, and saturates it to the velocity width. It then smooths the delta with a power-of-two moving average. The output feeds the speed loop and telemetry in the motor controller.

Parameters:
SAMPLE_CYCLES, 150000, clk cycles per sample period (1 kHz at 150 MHz); legal range is at least 4.
AVG_LOG2, 3, log2 of moving-average depth; legal range 0..4 (depth 1..16).
VEL_WIDTH, 24, signed width of delta and velocity outputs; legal range 8..32.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  estimator run enable; level-sensitive.
position_in  in  32  signed encoder position count.
delta_out  out  VEL_WIDTH  signed saturated position change over the last sample period.
velocity  out  VEL_WIDTH  signed moving average of delta_out, in counts per sample period.
velocity_valid  out  1  one-cycle pulse when velocity and delta_out update.
sat_flag  out  1  high if the latest delta was clipped; updates with velocity_valid.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - state = IDLE; tick counter = 0.
  - prev_pos = 0; all buffer entries = 0; accumulator = 0; write pointer = 0.
  - delta_out = 0, velocity = 0, velocity_valid = 0, sat_flag = 0.
- Tick counter:
  - Counts 0..SAMPLE_CYCLES-1 while enable=1, then wraps to 0.
  - "tick" is the cycle where counter == SAMPLE_CYCLES-1.
  - Counter is held at 0 while enable=0.
- State machine:
  - IDLE: on enable=1, go to PRIME (counter starts counting in the same cycle).
  - PRIME: at the first tick, latch prev_pos <= position_in, go to RUN. No valid pulse is produced.
  - RUN: at each tick, raw = position_in - prev_pos, computed in 32-bit modular arithmetic so counter wrap 0x7FFFFFFF -> 0x80000000 gives the correct small delta. Then prev_pos <= position_in.
  - Any state, enable=0: go to IDLE next cycle.
    - Clears counter, buffer, accumulator, pointer, delta_out, velocity, sat_flag.
    - velocity_valid = 0.
    - prev_pos is not used until the next PRIME.
- Saturation:
  - sat = clamp(raw, -2^(VEL_WIDTH-1), 2^(VEL_WIDTH-1)-1).
  - The sat_flag candidate is 1 iff clamping occurred.
  - When VEL_WIDTH = 32, no clamping occurs.
- Pipeline, with tick in cycle T:
  - T+1: delta_out <= sat; sat_flag <= clip bit.
  - T+1: buffer[wp] <= sat; acc <= acc + sat - buffer[wp] (old entry); wp <= wp + 1 mod depth.
  - T+2: velocity <= acc >>> AVG_LOG2 (arithmetic shift, floor toward -inf, truncated to VEL_WIDTH; cannot overflow); velocity_valid = 1 for exactly this cycle.
- Accumulator width is VEL_WIDTH + AVG_LOG2, signed; it never overflows.
- Fill behaviour: the buffer starts at zero, so the first depth-1 outputs ramp up (zeros are averaged in). No separate fill flag.
- Latency: tick to velocity_valid is 2 cycles. Valid pulses are spaced exactly SAMPLE_CYCLES apart in RUN.
- position_in is sampled only in the tick cycle. Changes at other times are ignored.
- If enable falls in cycle T+1 (pipeline in flight): the pending T+2 valid is suppressed and outputs clear.

Test Plan:
1. SAMPLE_CYCLES=1000, AVG_LOG2=2, VEL_WIDTH=24. Position +5 per period from 0 -> no valid at the prime tick; subsequent velocity = 1, 2, 3, 5, 5…; delta_out = 5 each time; sat_flag = 0; valids spaced 1000 cycles, 2 cycles after each tick.
2. Same config, position -3 per period -> velocity = -1, -2, -3, -3…; delta_out = -3.
3. Wrap: position 0x7FFFFFFE at prime tick, 0x80000003 at next tick -> delta_out = +5, sat_flag = 0.
4. VEL_WIDTH=8. Position jumps +200 in one period -> delta_out = 127, sat_flag = 1. Next period +10 -> delta_out = 10, sat_flag = 0. Repeat with -200 -> delta_out = -128, sat_flag = 1.
5. enable dropped one cycle after a tick in RUN -> no velocity_valid at T+2; velocity = 0, delta_out = 0 next cycle. Re-enable -> one PRIME tick with no valid, then averaging restarts from zero (ramp as in test 1).
6. reset asserted mid-RUN for 1 cycle -> all outputs 0 on the following cycle; FSM IDLE, then PRIME if enable=1. Also assert reset and enable together -> reset wins.
